// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage feeding the control unit.
// Holds the PC, issues one word fetch at a time over a req/ack handshake,
// registers the returned word and offers it to decode with valid/ready.
// Redirects from execute replace the PC and drop any in-flight word.
// Optional feature macro: FETCH_TIMEOUT_EN adds a fetch timeout counter,
// a sticky fetch_err flag and a terminal ERR state (left only via rst_n).
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [4:0]  id_opcode,
    output logic        fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0] S_ERR  = 2'd3;
    // Counter only needs to reach TIMEOUT_CYC-1.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_err_q, fetch_err_d;
`endif

    // Next-state and datapath update; redirect outranks ack and id_ready.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = '0;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d = redirect_pc & ~32'h3;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    // Any word returned this cycle belongs to the old path.
                    pc_d       = redirect_pc & ~32'h3;
                    id_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (imem_ack) begin
                    id_instr_d = imem_rdata;
                    id_pc_d    = pc_q;
                    id_valid_d = 1'b1;
                    state_d    = S_FULL;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc & ~32'h3;
                    id_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (id_ready) begin
                    pc_d       = pc_q + 32'd4;
                    id_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERR: begin
                // Terminal: ignore redirects, wait for reset.
                state_d    = S_ERR;
                id_valid_d = 1'b0;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_instr_q  <= 32'h0;
            id_pc_q     <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[6:2];
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios, a small instruction memory
// responder, and a scoreboard monitor that checks each fetch address and
// each newly presented instruction against hand-computed expectations.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  op;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  id_opcode;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    // memory responder controls
    bit mem_en    = 0;
    int mem_wait  = 0;
    bit mem_force = 0;
    int wait_cnt  = 0;
    logic prev_valid = 1'b0;

    inst_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tbl(input logic [31:0] a);
        case (a)
            32'h0000_0000: tbl = 32'h0000_0033;
            32'h0000_0004: tbl = 32'h0010_0093;
            32'h0000_0008: tbl = 32'h0000_0063;
            32'h0000_0100: tbl = 32'h0000_006F;
            32'h0000_0040: tbl = 32'h0000_0037;
            default:       tbl = 32'h0000_0013;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (id_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: id_valid stayed 0 for %0d cycles, required 1", nm, maxc);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] op);
        exp_t e;
        e.pc = pc; e.instr = instr; e.op = op;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_imem_req"},  32'(imem_req),  32'h0);
        chk({nm, "_imem_addr"}, imem_addr,      32'h0);
        chk({nm, "_id_valid"},  32'(id_valid),  32'h0);
        chk({nm, "_id_instr"},  id_instr,       32'h0);
        chk({nm, "_id_pc"},     id_pc,          32'h0);
        chk({nm, "_id_opcode"}, 32'(id_opcode), 32'h0);
        chk({nm, "_fetch_err"}, 32'(fetch_err), 32'h0);
    endtask

    // Instruction memory model: acks after mem_wait REQ cycles; mem_force injects a stray ack.
    always @(posedge clk) begin
        #1;
        if (mem_force) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end else if (mem_en && imem_req) begin
            if (wait_cnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = tbl(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack   = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard monitor: fetch addresses on each accepted request, instruction on each new valid.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
            end else begin
                chk("fetch_addr", imem_addr, addr_q.pop_front());
            end
        end
        if (id_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_instr", id_instr, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("id_pc",     id_pc,           e.pc);
                chk("id_instr",  id_instr,        e.instr);
                chk("id_opcode", 32'(id_opcode),  32'(e.op));
            end
        end
        prev_valid = id_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");

        // Release reset while a stray ack is present in IDLE: it must be ignored.
        mem_force = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        addr_q.push_back(32'h0);
        push_exp(32'h0, 32'h0000_0033, 5'b01100);
        @(negedge clk);
        chk("idle_ack_valid", 32'(id_valid), 32'h0);
        chk("idle_req", 32'(imem_req), 32'h0);
        mem_force = 0;
        mem_en    = 1;
        mem_wait  = 1;

        // Test 1: first fetch with one wait cycle.
        wait_valid(8, "first_fetch");
        chk("full_req_low", 32'(imem_req), 32'h0);

        // Ack while FULL is ignored.
        mem_force = 1;
        @(negedge clk);
        mem_force = 0;
        mem_wait  = 0;
        @(negedge clk);
        chk("full_ack_instr", id_instr, 32'h0000_0033);
        chk("full_ack_valid", 32'(id_valid), 32'h1);

        // Test 2: id_ready high, zero-wait memory -> valid every 2nd cycle.
        @(posedge clk); #1;
        id_ready = 1'b1;
        addr_q.push_back(32'h4);
        push_exp(32'h4, 32'h0010_0093, 5'b00100);
        addr_q.push_back(32'h8);
        push_exp(32'h8, 32'h0000_0063, 5'b11000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("valid_pulse", 32'(id_valid), (i % 2 == 0) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end

        // Test 3: redirect with id_ready in FULL.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        addr_q.push_back(32'h100);
        push_exp(32'h100, 32'h0000_006F, 5'b11011);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        @(negedge clk);
        chk("redir_addr",  imem_addr, 32'h0000_0100);
        chk("redir_valid", 32'(id_valid), 32'h0);
        chk("redir_req",   32'(imem_req), 32'h1);

        // Test 4: ack and redirect in the same REQ cycle.
        @(posedge clk); #1;
        id_ready = 1'b1;
        addr_q.push_back(32'h104);
        addr_q.push_back(32'h40);
        push_exp(32'h40, 32'h0000_0037, 5'b01101);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        @(negedge clk);
        chk("drop_req", 32'(imem_req), 32'h1);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        @(negedge clk);
        chk("drop_valid", 32'(id_valid), 32'h0);
        chk("drop_addr",  imem_addr, 32'h0000_0040);
        wait_valid(8, "after_drop");

        // Test 6: asynchronous reset while FULL.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        mem_en = 0;

        // Test 5: no ack at all after reset release.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("tmo_err_early", 32'(fetch_err), 32'h0);
        chk("tmo_req_early", 32'(imem_req),  32'h1);
        @(posedge clk);
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("tmo_err", 32'(fetch_err), 32'h1);
        chk("tmo_req", 32'(imem_req),  32'h0);
`else
        chk("tmo_err", 32'(fetch_err), 32'h0);
        chk("tmo_req", 32'(imem_req),  32'h1);
`endif
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("err_redir_req",  32'(imem_req), 32'h0);
        chk("err_redir_addr", imem_addr,     32'h0);
        chk("err_sticky",     32'(fetch_err), 32'h1);
`else
        chk("wait_redir_req",  32'(imem_req), 32'h1);
        chk("wait_redir_addr", imem_addr,     32'h0000_0200);
        chk("wait_no_err",     32'(fetch_err), 32'h0);
`endif
        chk("tmo_valid", 32'(id_valid), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("err_cleared", 32'(fetch_err), 32'h0);
        chk("err_rst_req", 32'(imem_req),  32'h0);

        repeat (2) @(posedge clk);
        chk("addr_q_drained", 32'(addr_q.size()), 32'h0);
        chk("exp_q_drained",  32'(exp_q.size()),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
